// File: rtl/timekeeper_pkg.sv
// Shared definitions for the timekeeping blocks (clk_period_meter, clk_divider).
package timekeeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TRACKING
  } state_e;

  localparam int unsigned TK_DATA_WIDTH     = 20;
  localparam int unsigned TK_DEFAULT_PERIOD = 500;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus a rising-edge detector.
// rise_pulse is combinational from the 2nd and 3rd flops: one cycle wide, fixed latency.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign rise_pulse = sync2_q & ~dly_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures ext_clk period in int_osc cycles, rejects glitches, averages the last
// 2^AVG_LOG2 intervals and drops lock when ext_clk stops for MAX_PERIOD cycles.
module clk_period_meter
  import timekeeper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = TK_DATA_WIDTH,
  parameter int unsigned DEFAULT_PERIOD = TK_DEFAULT_PERIOD,
  parameter int unsigned MIN_PERIOD     = 20,
  parameter int unsigned MAX_PERIOD     = 100000,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic                  int_osc,
  input  logic                  rst,
  input  logic                  ext_clk,
  output logic [DATA_WIDTH-1:0] master_period,
  output logic                  period_valid,
  output logic                  period_update,
  output logic                  locked
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SUM_W = DATA_WIDTH + AVG_LOG2;

  localparam logic [DATA_WIDTH-1:0] MIN_P = DATA_WIDTH'(MIN_PERIOD);
  localparam logic [DATA_WIDTH-1:0] MAX_P = DATA_WIDTH'(MAX_PERIOD);
  localparam logic [DATA_WIDTH-1:0] DEF_P = DATA_WIDTH'(DEFAULT_PERIOD);
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);
  localparam logic [PTR_W-1:0]      LAST  = PTR_W'(DEPTH - 1);

  logic rise;

  edge_sync u_edge_sync (
    .clk       (int_osc),
    .rst       (rst),
    .async_in  (ext_clk),
    .rise_pulse(rise)
  );

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hist_q [DEPTH];
  logic [DATA_WIDTH-1:0] hist_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_WIDTH-1:0] master_period_q, master_period_d;
  logic                  period_valid_q, period_valid_d;
  logic                  period_update_q, period_update_d;
  logic                  locked_q, locked_d;

  logic                  accept;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] cnt_inc;
  logic [SUM_W-1:0]      sum_roll;

  always_comb begin
    accept   = rise && ((state_q == ST_IDLE) || (cnt_q >= MIN_P));
    timeout  = (cnt_q == MAX_P) && !rise;
    cnt_inc  = (cnt_q == MAX_P) ? cnt_q : cnt_q + ONE;
    // The entry at wr_ptr is the oldest, so it is what leaves the window.
    sum_roll = sum_q + SUM_W'(cnt_q) - SUM_W'(hist_q[wr_ptr_q]);

    state_d         = state_q;
    cnt_d           = cnt_q;
    hist_d          = hist_q;
    wr_ptr_d        = wr_ptr_q;
    sum_d           = sum_q;
    master_period_d = master_period_q;
    period_valid_d  = period_valid_q;
    period_update_d = 1'b0;
    locked_d        = locked_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_ARMED;
          cnt_d   = ONE;
        end
      end
      ST_ARMED: begin
        if (accept) begin
          state_d = ST_TRACKING;
          cnt_d   = ONE;
          for (int unsigned i = 0; i < DEPTH; i++) hist_d[i] = cnt_q;
          sum_d           = SUM_W'(cnt_q) << AVG_LOG2;
          master_period_d = cnt_q;
          period_update_d = 1'b1;
          period_valid_d  = 1'b1;
          locked_d        = 1'b1;
        end else if (timeout) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_TRACKING: begin
        if (accept) begin
          cnt_d            = ONE;
          hist_d[wr_ptr_q] = cnt_q;
          wr_ptr_d         = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
          sum_d            = sum_roll;
          master_period_d  = sum_roll[SUM_W-1:AVG_LOG2];
          period_update_d  = 1'b1;
        end else if (timeout) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          locked_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge int_osc or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      wr_ptr_q        <= '0;
      sum_q           <= '0;
      master_period_q <= DEF_P;
      period_valid_q  <= 1'b0;
      period_update_q <= 1'b0;
      locked_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
      wr_ptr_q        <= wr_ptr_d;
      sum_q           <= sum_d;
      master_period_q <= master_period_d;
      period_valid_q  <= period_valid_d;
      period_update_q <= period_update_d;
      locked_q        <= locked_d;
    end
  end

  assign master_period = master_period_q;
  assign period_valid  = period_valid_q;
  assign period_update = period_update_q;
  assign locked        = locked_q;

endmodule
